// File: rtl/score_tracker_pkg.sv
// Shared constants for score_tracker: FSM state codes, winner codes and the
// active-low {g..a} seven-segment lookup used by score_seg7.
package score_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_PLAY      = 2'd0;
    localparam state_t ST_GOAL_HOLD = 2'd1;
    localparam state_t ST_REARM     = 2'd2;
    localparam state_t ST_GAME_OVER = 2'd3;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_T1   = 2'b01;
    localparam logic [1:0] WINNER_T2   = 2'b10;

    // Entry [d] is the active-low pattern for hex digit d; listed F down to 0.
    localparam logic [15:0][6:0] SEG_DIGIT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [6:0] SEG_RESET = 7'b1000000;

endpackage

// File: rtl/score_tracker_if.sv
// Score/HUD signal bundle between ball controller, score_tracker and display.
// Segment outputs exist only when SCORE_TRACKER_SEVEN_SEG_EN is defined.
interface score_tracker_if #(
    parameter int SCORE_WIDTH = 4
);
    logic                   score_to_team1;
    logic                   score_to_team2;
    logic                   restart_n;
    logic [SCORE_WIDTH-1:0] team1_score;
    logic [SCORE_WIDTH-1:0] team2_score;
    logic                   goal_flash;
    logic                   ball_respawn;
    logic                   game_over;
    logic [1:0]             winner;
`ifdef SCORE_TRACKER_SEVEN_SEG_EN
    logic [6:0]             team1_seg;
    logic [6:0]             team2_seg;

    modport master (
        output score_to_team1, score_to_team2, restart_n,
        input  team1_score, team2_score, goal_flash, ball_respawn,
               game_over, winner, team1_seg, team2_seg
    );

    modport slave (
        input  score_to_team1, score_to_team2, restart_n,
        output team1_score, team2_score, goal_flash, ball_respawn,
               game_over, winner, team1_seg, team2_seg
    );
`else
    modport master (
        output score_to_team1, score_to_team2, restart_n,
        input  team1_score, team2_score, goal_flash, ball_respawn,
               game_over, winner
    );

    modport slave (
        input  score_to_team1, score_to_team2, restart_n,
        output team1_score, team2_score, goal_flash, ball_respawn,
               game_over, winner
    );
`endif
endinterface

// File: rtl/score_tracker_seg7.sv
// Registered 4-bit hex to active-low seven-segment decoder ({g..a}).
module score_seg7
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_RESET;
        end else begin
            seg <= SEG_DIGIT[value];
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Per-team goal counter with goal-hold / respawn / rearm sequencing and winner
// detection. Optional seven-segment outputs under SCORE_TRACKER_SEVEN_SEG_EN.
module score_tracker
    import score_pkg::*;
#(
    parameter int WIN_SCORE        = 7,
    parameter int SCORE_WIDTH      = 4,
    parameter int GOAL_HOLD_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            rst_n,
    score_tracker_if.slave  bus
);

    localparam int TIMER_W = $clog2(GOAL_HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0]     HOLD_INIT = TIMER_W'(GOAL_HOLD_CYCLES - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL   = SCORE_WIDTH'(WIN_SCORE);

    generate
        if (WIN_SCORE < 1 || WIN_SCORE >= 2 ** SCORE_WIDTH) begin : g_bad_win
            $error("score_tracker: WIN_SCORE must be in 1 .. 2**SCORE_WIDTH-1");
        end
        if (GOAL_HOLD_CYCLES < 1) begin : g_bad_hold
            $error("score_tracker: GOAL_HOLD_CYCLES must be >= 1");
        end
    endgenerate

    state_t                   state;
    logic [TIMER_W-1:0]       timer;
    logic                     prev_t1, prev_t2;
    logic [SCORE_WIDTH-1:0]   t1_score, t2_score;
    logic                     respawn;
    logic [1:0]               win;

    logic                     rise1, rise2;
    logic [SCORE_WIDTH-1:0]   t1_inc, t2_inc;
    logic                     goal_wins;

    always_comb begin
        rise1     = bus.score_to_team1 & ~prev_t1;
        rise2     = bus.score_to_team2 & ~prev_t2;
        t1_inc    = t1_score + SCORE_WIDTH'(1);
        t2_inc    = t2_score + SCORE_WIDTH'(1);
        goal_wins = rise1 ? (t1_inc == WIN_VAL) : (t2_inc == WIN_VAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_PLAY;
            timer    <= '0;
            prev_t1  <= 1'b0;
            prev_t2  <= 1'b0;
            t1_score <= '0;
            t2_score <= '0;
            respawn  <= 1'b0;
            win      <= WINNER_NONE;
        end else begin
            // Edge registers track in every state so a held flag never re-counts.
            prev_t1 <= bus.score_to_team1;
            prev_t2 <= bus.score_to_team2;
            respawn <= 1'b0;
            case (state)
                ST_PLAY: begin
                    if (rise1 ^ rise2) begin
                        if (rise1) begin
                            t1_score <= t1_inc;
                        end else begin
                            t2_score <= t2_inc;
                        end
                        if (goal_wins) begin
                            state <= ST_GAME_OVER;
                            win   <= rise1 ? WINNER_T1 : WINNER_T2;
                        end else begin
                            state <= ST_GOAL_HOLD;
                            timer <= HOLD_INIT;
                        end
                    end
                end
                ST_GOAL_HOLD: begin
                    if (timer == '0) begin
                        state   <= ST_REARM;
                        respawn <= 1'b1;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_REARM: begin
                    if (!bus.score_to_team1 && !bus.score_to_team2) begin
                        state <= ST_PLAY;
                    end
                end
                ST_GAME_OVER: begin
                    if (!bus.restart_n) begin
                        t1_score <= '0;
                        t2_score <= '0;
                        win      <= WINNER_NONE;
                        respawn  <= 1'b1;
                        state    <= ST_REARM;
                    end
                end
                default: state <= ST_PLAY;
            endcase
        end
    end

    assign bus.team1_score  = t1_score;
    assign bus.team2_score  = t2_score;
    assign bus.goal_flash   = (state == ST_GOAL_HOLD);
    assign bus.ball_respawn = respawn;
    assign bus.game_over    = (state == ST_GAME_OVER);
    assign bus.winner       = win;

`ifdef SCORE_TRACKER_SEVEN_SEG_EN
    score_seg7 u_seg_t1 (
        .clk   (clk),
        .rst_n (rst_n),
        .value (4'(t1_score)),
        .seg   (bus.team1_seg)
    );

    score_seg7 u_seg_t2 (
        .clk   (clk),
        .rst_n (rst_n),
        .value (4'(t2_score)),
        .seg   (bus.team2_seg)
    );
`else
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker (WIN_SCORE=3, GOAL_HOLD_CYCLES=4):
// directed vector table, hand sequences, then randomized run vs. a reference model.
module tb_score_tracker;

    localparam int WIN  = 3;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    score_tracker_if #(.SCORE_WIDTH(4)) bus ();

    score_tracker #(
        .WIN_SCORE        (WIN),
        .SCORE_WIDTH      (4),
        .GOAL_HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit       r, a, b, s;
        int       e1, e2;
        bit       fl, rp, go;
        bit [1:0] w;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit a, input bit b, input bit s);
        rst_n              = r;
        bus.score_to_team1 = a;
        bus.score_to_team2 = b;
        bus.restart_n      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int e1, input int e2,
                             input bit fl, input bit rp, input bit go, input bit [1:0] w);
        chk({tag, "_t1"}, int'(bus.team1_score), e1);
        chk({tag, "_t2"}, int'(bus.team2_score), e2);
        chk({tag, "_flash"}, int'(bus.goal_flash), int'(fl));
        chk({tag, "_respawn"}, int'(bus.ball_respawn), int'(rp));
        chk({tag, "_over"}, int'(bus.game_over), int'(go));
        chk({tag, "_winner"}, int'(bus.winner), int'(w));
    endtask

    function automatic void add(bit r, bit a, bit b, bit s, int e1, int e2,
                                bit fl, bit rp, bit go, bit [1:0] w);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.s = s;
        v.e1 = e1; v.e2 = e2; v.fl = fl; v.rp = rp; v.go = go; v.w = w;
        vecs.push_back(v);
    endfunction

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference model: scores, remaining flash cycles, "must see flags clear" and game-over flag.
    int       m_s1, m_s2, m_hold_left;
    bit       m_need_clear, m_over, m_resp, m_prev1, m_prev2;
    bit [1:0] m_win;
    logic [6:0] m_seg1, m_seg2;

    task automatic model_step(input bit r, input bit a, input bit b, input bit s);
        bit r1, r2;
        m_seg1 = r ? seg_of(m_s1) : 7'b1000000;
        m_seg2 = r ? seg_of(m_s2) : 7'b1000000;
        m_resp = 0;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_hold_left = 0; m_need_clear = 0;
            m_over = 0; m_win = 0; m_prev1 = 0; m_prev2 = 0;
        end else begin
            r1 = a && !m_prev1;
            r2 = b && !m_prev2;
            if (m_over) begin
                if (!s) begin
                    m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 0;
                    m_resp = 1; m_need_clear = 1;
                end
            end else if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_resp = 1; m_need_clear = 1;
                end
            end else if (m_need_clear) begin
                if (!a && !b) m_need_clear = 0;
            end else if (r1 != r2) begin
                if (r1) m_s1++; else m_s2++;
                if (m_s1 == WIN || m_s2 == WIN) begin
                    m_over = 1;
                    m_win  = r1 ? 2'b01 : 2'b10;
                end else begin
                    m_hold_left = HOLD;
                end
            end
            m_prev1 = a;
            m_prev2 = b;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ra, rb, rs, rr;

        // Reset, long team1 goal, simultaneous rise, team2 goal.
        add(0,0,0,1, 0,0, 0,0,0, 2'b00);
        add(0,0,0,1, 0,0, 0,0,0, 2'b00);
        add(1,0,0,1, 0,0, 0,0,0, 2'b00);
        add(1,1,0,1, 1,0, 1,0,0, 2'b00);
        for (int i = 0; i < 3; i++) add(1,1,0,1, 1,0, 1,0,0, 2'b00);
        add(1,1,0,1, 1,0, 0,1,0, 2'b00);
        for (int i = 0; i < 15; i++) add(1,1,0,1, 1,0, 0,0,0, 2'b00);
        add(1,0,0,1, 1,0, 0,0,0, 2'b00);
        add(1,1,1,1, 1,0, 0,0,0, 2'b00);
        add(1,1,1,1, 1,0, 0,0,0, 2'b00);
        add(1,0,0,1, 1,0, 0,0,0, 2'b00);
        add(1,0,1,1, 1,1, 1,0,0, 2'b00);
        for (int i = 0; i < 3; i++) add(1,0,1,1, 1,1, 1,0,0, 2'b00);
        add(1,0,0,1, 1,1, 0,1,0, 2'b00);
        add(1,0,0,1, 1,1, 0,0,0, 2'b00);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].s);
            check_all($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2,
                      vecs[i].fl, vecs[i].rp, vecs[i].go, vecs[i].w);
        end

        // Team2 wins, extra goals ignored, restart.
        apply(0,0,0,1);
        apply(1,0,0,1);
        for (int g = 1; g <= 2; g++) begin
            apply(1,0,1,1); check_all("t2goal", 0, g, 1, 0, 0, 2'b00);
            for (int k = 0; k < 3; k++) apply(1,0,0,1);
            apply(1,0,0,1); check_all("t2resp", 0, g, 0, 1, 0, 2'b00);
            apply(1,0,0,1);
        end
        apply(1,0,1,1); check_all("t2win", 0, 3, 0, 0, 1, 2'b10);
        apply(1,0,0,1);
        apply(1,0,1,1); check_all("over_t2", 0, 3, 0, 0, 1, 2'b10);
        apply(1,1,0,1); check_all("over_t1", 0, 3, 0, 0, 1, 2'b10);
        apply(1,0,0,0); check_all("restart", 0, 0, 0, 1, 0, 2'b00);
        apply(1,0,0,1); check_all("rearm", 0, 0, 0, 0, 0, 2'b00);
        apply(1,1,0,1); check_all("post_restart", 1, 0, 1, 0, 0, 2'b00);
`ifdef SCORE_TRACKER_SEVEN_SEG_EN
        chk("seg_before", int'(bus.team1_seg), int'(7'b1000000));
`endif
        apply(1,1,0,1);
`ifdef SCORE_TRACKER_SEVEN_SEG_EN
        chk("seg_after", int'(bus.team1_seg), int'(7'b1111001));
`endif

        // Reset in the middle of the hold aborts everything.
        apply(0,0,0,1); check_all("mid_reset", 0, 0, 0, 0, 0, 2'b00);
        for (int k = 0; k < 6; k++) begin
            apply(1,0,0,1); check_all("after_reset", 0, 0, 0, 0, 0, 2'b00);
        end

        // Randomized run against the reference model.
        ra = 0; rb = 0;
        model_step(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(5) == 0) ra = ~ra;
            if ($urandom_range(5) == 0) rb = ~rb;
            rs = ($urandom_range(7) != 0);
            rr = ($urandom_range(199) != 0);
            model_step(rr, ra, rb, rs);
            apply(rr, ra, rb, rs);
            check_all("rand", m_s1, m_s2, m_hold_left > 0, m_resp, m_over, m_win);
`ifdef SCORE_TRACKER_SEVEN_SEG_EN
            chk("rand_seg1", int'(bus.team1_seg), int'(m_seg1));
            chk("rand_seg2", int'(bus.team2_seg), int'(m_seg2));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
